// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_t;

  localparam logic [31:0] NOP_INST   = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Circular FIFO holding fetched {instruction, pc+4} pairs; head is read combinationally.
module inst_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [CntW-1:0]  count,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: owns the fetch PC, runs one outstanding memory request at a time
// and queues fetched words for IF/ID; an ID redirect flushes and restarts fetch.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        consume,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc_plus4
);

  localparam int unsigned CntW     = $clog2(DEPTH + 1);
  localparam logic [CntW:0] DepthLim = (CntW + 1)'(DEPTH);

  fetch_state_t    state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     next_addr, target_pc;
  logic            push, pop, q_empty, q_full;
  logic [CntW-1:0] q_count;
  logic [CntW:0]   count_after;
  logic [63:0]     q_head;

  assign pop         = consume && !q_empty;
  assign next_addr   = mem_addr_q + WORD_BYTES;
  assign target_pc   = word_align(redirect_pc);
  // Occupancy after this cycle's push of the returning word and any head pop.
  assign count_after = {1'b0, q_count} + (CntW + 1)'(1) - (CntW + 1)'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = target_pc;
        end else if (!q_full || pop) begin
          mem_addr_d = fetch_pc_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          fetch_pc_d = target_pc;
          state_d    = mem_ack ? IDLE : DROP;
        end else if (mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = next_addr;
          if (count_after < DepthLim) begin
            mem_addr_d = next_addr;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (redirect) fetch_pc_d = target_pc;
        if (mem_ack)  state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  inst_queue #(
    .WIDTH(64),
    .DEPTH(DEPTH)
  ) u_inst_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data({mem_rdata, next_addr}),
    .pop      (pop),
    .clear    (redirect),
    .count    (q_count),
    .empty    (q_empty),
    .full     (q_full),
    .head     (q_head)
  );

  assign mem_req    = (state_q != IDLE);
  assign mem_addr   = mem_addr_q;
  assign inst_valid = !q_empty;
  assign inst       = q_empty ? NOP_INST : q_head[63:32];
  assign pc_plus4   = q_empty ? 32'h0 : q_head[31:0];

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench for fetch_prefetch_unit: a grant-limited memory model with
// configurable latency, expected request addresses and delivered entries queued up front.
module tb_fetch_prefetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        consume;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc_plus4;
  logic        force_ack;

  int lat         = 0;
  int grant_total = 0;
  int wait_cnt;
  int acks_done;
  int tests       = 0;
  int fails       = 0;

  logic [31:0] exp_addr[$];
  logic [63:0] exp_inst[$];

  fetch_prefetch_unit #(
    .DEPTH   (4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .consume    (consume),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .pc_plus4   (pc_plus4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory model: acks after `lat` wait cycles, at most grant_total times per reset.
  assign mem_rdata = word_of(mem_addr);
  assign mem_ack   = force_ack || (mem_req && (acks_done < grant_total) && (wait_cnt >= lat));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= 0;
      acks_done <= 0;
    end else if (mem_req && mem_ack) begin
      wait_cnt  <= 0;
      acks_done <= acks_done + 1;
    end else if (mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    exp_addr.push_back(a);
  endtask

  task automatic expect_inst(input logic [31:0] a);
    exp_inst.push_back({word_of(a), a + 32'd4});
  endtask

  task automatic do_reset(input int lat_v, input int grants_v);
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    consume     = 1'b0;
    force_ack   = 1'b0;
    lat         = lat_v;
    grant_total = grants_v;
    exp_addr.delete();
    exp_inst.delete();
    tick();
    tick();
    check32("rst_mem_req", mem_req, 0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check32("rst_inst_valid", inst_valid, 0);
    check32("rst_inst", inst, 32'h0);
    check32("rst_pc_plus4", pc_plus4, 32'h0);
    rst = 1'b0;
  endtask

  task automatic check_drained(input string name);
    check32({name, "_addr_left"}, exp_addr.size(), 0);
    check32({name, "_inst_left"}, exp_inst.size(), 0);
  endtask

  // Monitor: every request cycle must show the next expected address; every
  // delivered head must match the next expected entry.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_req && exp_addr.size() != 0) begin
          check32("mem_addr", mem_addr, exp_addr[0]);
          if (mem_ack) void'(exp_addr.pop_front());
        end else if (mem_req && mem_ack) begin
          tests++;
          fails++;
          $display("FAIL extra_ack: addr %h acked with nothing expected", mem_addr);
        end
        if (inst_valid && consume && !redirect) begin
          if (exp_inst.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_inst: got pc_plus4 %h, expected no delivery", pc_plus4);
          end else begin
            e = exp_inst.pop_front();
            check32("inst", inst, e[63:32]);
            check32("pc_plus4", pc_plus4, e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  acyc[$];
    bit  found;

    // Zero-wait streaming with continuous consume.
    do_reset(0, 8);
    for (int i = 0; i < 8; i++) begin
      expect_fetch(32'(4 * i));
      expect_inst(32'(4 * i));
    end
    consume = 1'b1;
    check32("p1_req_before", mem_req, 0);
    tick();
    check32("p1_req_rise", mem_req, 1);
    check32("p1_first_addr", mem_addr, 32'h0);
    check32("p1_valid_c1", inst_valid, 0);
    tick();
    check32("p1_valid_c2", inst_valid, 1);
    check32("p1_pc4_c2", pc_plus4, 32'h4);
    repeat (14) tick();
    check_drained("p1");

    // Fill to DEPTH with no consume, then drain and resume at 0x10.
    do_reset(0, 6);
    for (int i = 0; i < 6; i++) expect_fetch(32'(4 * i));
    repeat (10) tick();
    check32("p2_acks", acks_done, 4);
    check32("p2_req_idle", mem_req, 0);
    check32("p2_valid_full", inst_valid, 1);
    check32("p2_head_pc4", pc_plus4, 32'h4);
    for (int i = 0; i < 6; i++) expect_inst(32'(4 * i));
    consume = 1'b1;
    repeat (16) tick();
    check_drained("p2");

    // Three wait cycles per request: one word every four cycles.
    do_reset(3, 3);
    for (int i = 0; i < 3; i++) begin
      expect_fetch(32'(4 * i));
      expect_inst(32'(4 * i));
    end
    consume = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_req && mem_ack) acyc.push_back(i);
    end
    check32("p3_ack_count", acyc.size(), 3);
    if (acyc.size() == 3) begin
      check32("p3_gap0", acyc[1] - acyc[0], 4);
      check32("p3_gap1", acyc[2] - acyc[1], 4);
    end
    check_drained("p3");

    // Redirect while waiting on 0x8: the late ack is dropped, then fetch 0x40.
    do_reset(3, 5);
    expect_fetch(32'h0);
    expect_fetch(32'h4);
    expect_fetch(32'h8);
    expect_fetch(32'h40);
    expect_fetch(32'h44);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = mem_req && (mem_addr == 32'h8);
    end
    check32("p4_reach_8", found, 1);
    redirect    = 1'b1;
    redirect_pc = 32'h43;
    tick();
    redirect = 1'b0;
    check32("p4_flush", inst_valid, 0);
    check32("p4_drop_req", mem_req, 1);
    check32("p4_drop_addr", mem_addr, 32'h8);
    expect_inst(32'h40);
    expect_inst(32'h44);
    consume = 1'b1;
    repeat (30) tick();
    check_drained("p4");

    // Redirect coincident with the ack for 0x8.
    do_reset(3, 5);
    expect_fetch(32'h0);
    expect_fetch(32'h4);
    expect_fetch(32'h8);
    expect_fetch(32'h100);
    expect_fetch(32'h104);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = mem_req && mem_ack && (mem_addr == 32'h8);
    end
    check32("p5_reach_ack8", found, 1);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check32("p5_flush", inst_valid, 0);
    check32("p5_idle", mem_req, 0);
    expect_inst(32'h100);
    expect_inst(32'h104);
    consume = 1'b1;
    tick();
    check32("p5_req", mem_req, 1);
    check32("p5_addr", mem_addr, 32'h100);
    repeat (25) tick();
    check_drained("p5");

    // Asynchronous reset mid-request, then a stale ack while idle.
    do_reset(0, 0);
    repeat (3) tick();
    check32("p6_req_hi", mem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    check32("p6_async_req", mem_req, 0);
    check32("p6_async_addr", mem_addr, 32'h0);
    @(posedge clk);
    #1;
    force_ack   = 1'b1;
    grant_total = 1;
    expect_fetch(32'h0);
    expect_inst(32'h0);
    consume = 1'b1;
    rst     = 1'b0;
    tick();
    force_ack = 1'b0;
    check32("p6_stale_ignored", inst_valid, 0);
    repeat (8) tick();
    check_drained("p6");
    check32("p6_empty_end", inst_valid, 0);

    // Address wrap past the top of memory.
    do_reset(0, 0);
    repeat (3) tick();
    expect_fetch(32'h0);
    expect_fetch(32'hFFFF_FFFC);
    expect_fetch(32'h0);
    exp_inst.push_back({word_of(32'hFFFF_FFFC), 32'h0});
    expect_inst(32'h0);
    consume     = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    grant_total = 3;
    tick();
    redirect = 1'b0;
    repeat (10) tick();
    check_drained("p7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction-fetch front end. Sits directly upstream of the IF/ID pipeline register and replaces the direct PC-to-instruction-memory path.
- Owns the fetch PC and talks to a variable-latency instruction memory over a req/ack handshake.
- Buffers fetched words with their PC+4 in a small queue and presents one instruction per cycle to IF/ID.
- A redirect from ID (taken branch or jump) flushes the queue and restarts fetch at the target.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- redirect  input  1  ID-stage branch/jump taken; flush and restart fetch.
- redirect_pc  input  32  restart target; valid when redirect=1.
- consume  input  1  IF/ID accepts the head entry this cycle (IF/ID write enable).
- mem_req  output  1  instruction memory request.
- mem_addr  output  32  request address; word aligned.
- mem_ack  input  1  memory returns mem_rdata for the current request.
- mem_rdata  input  32  instruction word.
- inst_valid  output  1  queue head valid.
- inst  output  32  head instruction; 32'h0 (NOP) when inst_valid=0.
- pc_plus4  output  32  head instruction address + 4; 0 when inst_valid=0.

Behaviour:
- Reset (async, rst=1):
  - fetch_pc=RESET_PC, queue empty, state=IDLE.
  - mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst=0, pc_plus4=0.
- State machine: IDLE, WAIT, DROP. Only one request is outstanding at a time.
  - mem_req=1 exactly in WAIT and DROP.
  - mem_addr is registered. It stays stable and mem_req stays high until mem_ack; a request is never withdrawn.
- IDLE:
  - if redirect: fetch_pc<=redirect_pc, queue cleared, stay IDLE.
  - else if count<DEPTH: mem_addr<=fetch_pc, go WAIT.
  - First mem_req rises one cycle after reset deassertion.
- WAIT, no ack:
  - redirect: queue cleared, fetch_pc<=redirect_pc, go DROP.
  - otherwise hold.
- WAIT, ack:
  - redirect same cycle: mem_rdata discarded, queue cleared, fetch_pc<=redirect_pc, go IDLE.
  - else push {mem_rdata, mem_addr+4} and set fetch_pc<=mem_addr+4.
  - Then, if post-push/pop count<DEPTH: stay WAIT with mem_addr<=mem_addr+4. This gives back-to-back fetch, one word per cycle with a zero-wait memory.
  - Otherwise go IDLE.
- DROP:
  - On ack: discard data, go IDLE.
  - A redirect while in DROP only updates fetch_pc; the latest redirect wins.
- Queue:
  - Circular buffer with wrapping read/write pointers and count 0..DEPTH.
  - Pop when consume && inst_valid. consume while empty is ignored.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Never overflows, because a request is issued only when count (after the same-cycle pop) < DEPTH.
  - Head is combinational from storage. A pushed entry is visible the cycle after ack (fill latency 1).
- Priority: rst > redirect > push/pop.
  - Redirect clears the queue even if consume=1; the head is not delivered.
  - inst_valid=0 in the cycle after a redirect.
- Address arithmetic: 32-bit, modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0 with no flag. Bits [1:0] of redirect_pc are forced to 0.
- Reset mid-WAIT: mem_req drops immediately (async). The memory side must tolerate an abandoned request; any later ack is ignored while in IDLE.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum {IDLE, WAIT, DROP}.
  - NOP_INST = 32'h0.
  - WORD_BYTES = 4.
- One sub-module: inst_queue, a parameterized synchronous FIFO (WIDTH=64, DEPTH), with push, pop, clear, count, empty, full, head.
- The FSM and PC logic stay in fetch_prefetch_unit.

Test Plan:
- Reset with RESET_PC=0, zero-wait memory (ack every mem_req cycle), consume=1 -> mem_addr 0,4,8,... on consecutive cycles. inst_valid from cycle 2; pc_plus4 = 4,8,12.
- consume=0, zero-wait memory, DEPTH=4 -> exactly 4 acks, then mem_req=0, count=4. Raise consume -> entries drain in order, and fetching resumes at 0x10.
- Memory with 3-cycle ack latency -> mem_addr held stable for 3 cycles with mem_req=1. One instruction every 4 cycles, no duplicates.
- In WAIT at addr 0x8 (no ack), redirect=1, redirect_pc=0x40 -> queue empties. The next ack is discarded (DROP), and the next request is addr 0x40.
- Redirect to 0x100 coincident with ack for 0x8 -> word discarded, inst_valid=0 next cycle, next mem_addr=0x100.
- rst pulse while mem_req=1 -> mem_req falls without a clock edge. After release, fetch restarts at RESET_PC and a stale ack in IDLE has no effect.
